// File: rtl/crd_hold_if.sv
// Coordinate stream bundle for crd_hold: two input streams (inner _0, outer _1)
// and two aligned output streams. slave = block view, master = driver view.
interface crd_hold_if;
    logic [16:0] cmrg_coord_in_0;
    logic        cmrg_coord_in_0_valid;
    logic        cmrg_coord_in_0_ready;
    logic [16:0] cmrg_coord_in_1;
    logic        cmrg_coord_in_1_valid;
    logic        cmrg_coord_in_1_ready;
    logic [16:0] cmrg_coord_out_0;
    logic        cmrg_coord_out_0_valid;
    logic        cmrg_coord_out_0_ready;
    logic [16:0] cmrg_coord_out_1;
    logic        cmrg_coord_out_1_valid;
    logic        cmrg_coord_out_1_ready;

    modport slave (
        input  cmrg_coord_in_0, cmrg_coord_in_0_valid, cmrg_coord_in_1, cmrg_coord_in_1_valid,
        input  cmrg_coord_out_0_ready, cmrg_coord_out_1_ready,
        output cmrg_coord_in_0_ready, cmrg_coord_in_1_ready,
        output cmrg_coord_out_0, cmrg_coord_out_0_valid, cmrg_coord_out_1, cmrg_coord_out_1_valid
    );

    modport master (
        output cmrg_coord_in_0, cmrg_coord_in_0_valid, cmrg_coord_in_1, cmrg_coord_in_1_valid,
        output cmrg_coord_out_0_ready, cmrg_coord_out_1_ready,
        input  cmrg_coord_in_0_ready, cmrg_coord_in_1_ready,
        input  cmrg_coord_out_0, cmrg_coord_out_0_valid, cmrg_coord_out_1, cmrg_coord_out_1_valid
    );
endinterface

// File: rtl/crd_hold.sv
// Outer-coordinate hold: repeats the current outer coordinate once per inner token.
// Define CRD_HOLD_OUT_REG_EN to put a 2-entry FIFO on each output (1-cycle latency).
module crd_hold (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        tile_en,
    input  logic        cmrg_enable,
    input  logic [15:0] cmrg_stop_lvl,
    crd_hold_if.slave   bus
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, nxt;
    logic [15:0] held;
    logic        clr, run, go;
    logic        latch, emit_req, emit_ok, fire, in0_rdy, in1_rdy;
    logic [16:0] in0_d, in1_d, v0, v1;
    logic        in0_v, in1_v, tok0, tok1, done0, done1;
    logic        unused;

    assign unused = ^{cmrg_enable, cmrg_stop_lvl};

    // rst_n is an active-high reset despite its name
    assign clr   = rst_n | flush;
    assign run   = clk_en & tile_en;
    assign go    = run & ~clr;

    assign in0_d = bus.cmrg_coord_in_0;
    assign in1_d = bus.cmrg_coord_in_1;
    assign in0_v = bus.cmrg_coord_in_0_valid;
    assign in1_v = bus.cmrg_coord_in_1_valid;
    assign tok0  = in0_d[16];
    assign tok1  = in1_d[16];
    assign done0 = in0_d[16] & in0_d[8];
    assign done1 = in1_d[16] & in1_d[8];

    // Inner stop/done tokens pass to both outputs; coordinates pair with held.
    assign v0 = in0_d;
    assign v1 = tok0 ? in0_d : {1'b0, held};

    always_comb begin
        nxt      = state;
        latch    = 1'b0;
        emit_req = 1'b0;
        in0_rdy  = 1'b0;
        in1_rdy  = 1'b0;
        if (go) begin
            case (state)
                FETCH: begin
                    // A done outer head waits for the inner done so both pop together.
                    in1_rdy  = emit_ok & (~done1 | (in0_v & done0));
                    in0_rdy  = emit_ok & in1_v & done1 & done0;
                    emit_req = in1_v & in0_v & done1 & done0;
                    if (in1_v & in1_rdy & ~tok1) begin
                        latch = 1'b1;
                        nxt   = HOLD;
                    end
                end
                HOLD: begin
                    in0_rdy  = emit_ok & ~done0;
                    emit_req = in0_v & ~done0;
                    if (in0_v & done0)
                        nxt = FETCH;
                    else if (in0_v & in0_rdy & tok0)
                        nxt = FETCH;
                end
            endcase
        end
    end

    assign fire = emit_req & emit_ok;
    assign bus.cmrg_coord_in_0_ready = in0_rdy;
    assign bus.cmrg_coord_in_1_ready = in1_rdy;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= FETCH;
            held  <= '0;
        end else if (run) begin
            state <= nxt;
            if (latch)
                held <= in1_d[15:0];
        end
    end

`ifdef CRD_HOLD_OUT_REG_EN
    logic [16:0] fmem [2][2];
    logic [16:0] push_d [2];
    logic [1:0]  cnt [2];
    logic [1:0]  rp, wp, ov, ordy, pop;

    assign push_d[0] = v0;
    assign push_d[1] = v1;
    assign ordy      = {bus.cmrg_coord_out_1_ready, bus.cmrg_coord_out_0_ready};
    assign emit_ok   = (cnt[0] != 2'd2) & (cnt[1] != 2'd2);

    always_comb begin
        ov  = '0;
        pop = '0;
        for (int i = 0; i < 2; i++) begin
            ov[i]  = go & (cnt[i] != 2'd0);
            pop[i] = ov[i] & ordy[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rp     <= '0;
            wp     <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fire) begin
                    fmem[i][wp[i]] <= push_d[i];
                    wp[i]          <= ~wp[i];
                end
                if (pop[i])
                    rp[i] <= ~rp[i];
                cnt[i] <= cnt[i] + {1'b0, fire} - {1'b0, pop[i]};
            end
        end
    end

    assign bus.cmrg_coord_out_0_valid = ov[0];
    assign bus.cmrg_coord_out_1_valid = ov[1];
    assign bus.cmrg_coord_out_0       = ov[0] ? fmem[0][rp[0]] : '0;
    assign bus.cmrg_coord_out_1       = ov[1] ? fmem[1][rp[1]] : '0;
`else
    // Outputs move as a pair: nothing is emitted unless both sinks take it this cycle.
    assign emit_ok = bus.cmrg_coord_out_0_ready & bus.cmrg_coord_out_1_ready;

    assign bus.cmrg_coord_out_0_valid = emit_req;
    assign bus.cmrg_coord_out_1_valid = emit_req;
    assign bus.cmrg_coord_out_0       = emit_req ? v0 : '0;
    assign bus.cmrg_coord_out_1       = emit_req ? v1 : '0;
`endif
endmodule

// File: tb/tb_crd_hold.sv
// Directed bench for crd_hold: basic/empty-fiber tiles, backpressure, back-to-back,
// flush and enable gating, each compared against hand-derived token streams.
module tb_crd_hold;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        tile_en = 1'b1;
    logic        cmrg_enable = 1'b0;
    logic [15:0] cmrg_stop_lvl = '0;

    crd_hold_if bus();

    crd_hold dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .cmrg_enable(cmrg_enable), .cmrg_stop_lvl(cmrg_stop_lvl), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [16:0] q_out[$], q_in[$], cap0[$], cap1[$];

    logic [16:0] b_o0 [6] = '{17'h0, 17'h2, S0, 17'h1, S1, DN};
    logic [16:0] b_o1 [6] = '{17'h0, 17'h0, S0, 17'h1, S1, DN};
    logic [16:0] e_o0 [4] = '{S0, 17'h7, S1, DN};
    logic [16:0] e_o1 [4] = '{S0, 17'h4, S1, DN};

    task automatic load_basic();
        q_out.push_back(17'h0); q_out.push_back(17'h1); q_out.push_back(S0); q_out.push_back(DN);
        q_in.push_back(17'h0);  q_in.push_back(17'h2);  q_in.push_back(S0);
        q_in.push_back(17'h1);  q_in.push_back(S1);     q_in.push_back(DN);
    endtask

    task automatic present_heads();
        if (q_in.size() > 0) begin
            bus.cmrg_coord_in_0 = q_in[0]; bus.cmrg_coord_in_0_valid = 1'b1;
        end
        if (q_out.size() > 0) begin
            bus.cmrg_coord_in_1 = q_out[0]; bus.cmrg_coord_in_1_valid = 1'b1;
        end
    endtask

    // Feeds queued tokens and collects output transfers until n_exp are captured
    // on each output. Called just after a rising edge. Also checks stall stability.
    task automatic run_stream(input int n_exp, input bit rnd, output bit tmo);
        bit f0, f1, o0, o1, st0, st1;
        logic [16:0] d0p, d1p;
        tmo = 1'b0; st0 = 1'b0; st1 = 1'b0; d0p = '0; d1p = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cap0.size() >= n_exp && cap1.size() >= n_exp) return;
            if (!bus.cmrg_coord_in_1_valid && q_out.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
                bus.cmrg_coord_in_1 = q_out[0]; bus.cmrg_coord_in_1_valid = 1'b1;
            end
            if (!bus.cmrg_coord_in_0_valid && q_in.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
                bus.cmrg_coord_in_0 = q_in[0]; bus.cmrg_coord_in_0_valid = 1'b1;
            end
            bus.cmrg_coord_out_0_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.cmrg_coord_out_1_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (st0) begin
                n_chk++;
                if (bus.cmrg_coord_out_0_valid !== 1'b1 || bus.cmrg_coord_out_0 !== d0p)
                    $display("FAIL stall_hold_0: got v=%b d=%h required v=1 d=%h",
                             bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_0, d0p);
                else n_pass++;
            end
            if (st1) begin
                n_chk++;
                if (bus.cmrg_coord_out_1_valid !== 1'b1 || bus.cmrg_coord_out_1 !== d1p)
                    $display("FAIL stall_hold_1: got v=%b d=%h required v=1 d=%h",
                             bus.cmrg_coord_out_1_valid, bus.cmrg_coord_out_1, d1p);
                else n_pass++;
            end
            f0 = bus.cmrg_coord_in_0_valid & bus.cmrg_coord_in_0_ready;
            f1 = bus.cmrg_coord_in_1_valid & bus.cmrg_coord_in_1_ready;
`ifdef CRD_HOLD_OUT_REG_EN
            o0 = bus.cmrg_coord_out_0_valid & bus.cmrg_coord_out_0_ready;
            o1 = bus.cmrg_coord_out_1_valid & bus.cmrg_coord_out_1_ready;
`else
            // unregistered outputs only move as a pair
            o0 = bus.cmrg_coord_out_0_valid & bus.cmrg_coord_out_0_ready &
                 bus.cmrg_coord_out_1_valid & bus.cmrg_coord_out_1_ready;
            o1 = o0;
`endif
            if (o0) cap0.push_back(bus.cmrg_coord_out_0);
            if (o1) cap1.push_back(bus.cmrg_coord_out_1);
            st0 = bus.cmrg_coord_out_0_valid & ~o0; d0p = bus.cmrg_coord_out_0;
            st1 = bus.cmrg_coord_out_1_valid & ~o1; d1p = bus.cmrg_coord_out_1;
            @(posedge clk); #1;
            if (f0) begin void'(q_in.pop_front());  bus.cmrg_coord_in_0_valid = 1'b0; end
            if (f1) begin void'(q_out.pop_front()); bus.cmrg_coord_in_1_valid = 1'b0; end
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset();
        bus.cmrg_coord_in_0 = DN; bus.cmrg_coord_in_0_valid = 1'b1;
        bus.cmrg_coord_in_1 = DN; bus.cmrg_coord_in_1_valid = 1'b1;
        bus.cmrg_coord_out_0_ready = 1'b1; bus.cmrg_coord_out_1_ready = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.cmrg_coord_in_0_ready, bus.cmrg_coord_in_1_ready} !== 2'b00)
            $display("FAIL reset_readies: got %b required 00", {bus.cmrg_coord_in_0_ready, bus.cmrg_coord_in_1_ready});
        else n_pass++;
        n_chk++;
        if ({bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid} !== 2'b00)
            $display("FAIL reset_valids: got %b required 00", {bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid});
        else n_pass++;
        n_chk++;
        if (bus.cmrg_coord_out_0 !== 17'h0 || bus.cmrg_coord_out_1 !== 17'h0)
            $display("FAIL reset_data: got %h/%h required 0/0", bus.cmrg_coord_out_0, bus.cmrg_coord_out_1);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.cmrg_coord_in_0_valid = 1'b0; bus.cmrg_coord_in_1_valid = 1'b0;
        bus.cmrg_coord_in_0 = '0; bus.cmrg_coord_in_1 = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit tmo;
        logic [16:0] g;
        cap0.delete(); cap1.delete(); load_basic();
        run_stream(6, 1'b0, tmo);
        n_chk++;
        if (tmo) $display("FAIL basic_timeout: got %0d/%0d tokens required 6", cap0.size(), cap1.size());
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
            if (g !== b_o0[i]) $display("FAIL basic_out0[%0d]: got %h required %h", i, g, b_o0[i]);
            else n_pass++;
            n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
            if (g !== b_o1[i]) $display("FAIL basic_out1[%0d]: got %h required %h", i, g, b_o1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_empty_fiber();
        bit tmo;
        logic [16:0] g;
        cap0.delete(); cap1.delete();
        q_out.push_back(17'h3); q_out.push_back(17'h4); q_out.push_back(S0); q_out.push_back(DN);
        q_in.push_back(S0); q_in.push_back(17'h7); q_in.push_back(S1); q_in.push_back(DN);
        run_stream(4, 1'b0, tmo);
        n_chk++;
        if (tmo) $display("FAIL empty_timeout: got %0d/%0d tokens required 4", cap0.size(), cap1.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
            if (g !== e_o0[i]) $display("FAIL empty_out0[%0d]: got %h required %h", i, g, e_o0[i]);
            else n_pass++;
            n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
            if (g !== e_o1[i]) $display("FAIL empty_out1[%0d]: got %h required %h", i, g, e_o1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit tmo;
        logic [16:0] g;
        for (int rep = 0; rep < 3; rep++) begin
            cap0.delete(); cap1.delete(); load_basic();
            run_stream(6, 1'b1, tmo);
            repeat (4) begin
                @(negedge clk);
                if (bus.cmrg_coord_out_0_valid & bus.cmrg_coord_out_0_ready) cap0.push_back(bus.cmrg_coord_out_0);
                if (bus.cmrg_coord_out_1_valid & bus.cmrg_coord_out_1_ready) cap1.push_back(bus.cmrg_coord_out_1);
                @(posedge clk); #1;
            end
            n_chk++;
            if (tmo || cap0.size() != 6 || cap1.size() != 6)
                $display("FAIL bp_count: got %0d/%0d tokens required 6/6", cap0.size(), cap1.size());
            else n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
                if (g !== b_o0[i]) $display("FAIL bp_out0[%0d]: got %h required %h", i, g, b_o0[i]);
                else n_pass++;
                n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
                if (g !== b_o1[i]) $display("FAIL bp_out1[%0d]: got %h required %h", i, g, b_o1[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        logic [16:0] g;
        cap0.delete(); cap1.delete(); load_basic(); load_basic();
        run_stream(12, 1'b0, tmo);
        n_chk++;
        if (tmo) $display("FAIL b2b_timeout: got %0d/%0d tokens required 12", cap0.size(), cap1.size());
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
            if (g !== b_o0[i % 6]) $display("FAIL b2b_out0[%0d]: got %h required %h", i, g, b_o0[i % 6]);
            else n_pass++;
            n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
            if (g !== b_o1[i % 6]) $display("FAIL b2b_out1[%0d]: got %h required %h", i, g, b_o1[i % 6]);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        bit tmo;
        logic [16:0] g;
        cap0.delete(); cap1.delete(); load_basic();
        run_stream(1, 1'b0, tmo);
        n_chk++;
        if (tmo || cap0.size() < 1 || cap0[0] !== 17'h0 || cap1[0] !== 17'h0)
            $display("FAIL flush_pre: got %0d tokens required first pair 0/0", cap0.size());
        else n_pass++;
        present_heads();
        flush = 1'b1;
`ifdef CRD_HOLD_OUT_REG_EN
        @(posedge clk); #1;
`endif
        @(negedge clk);
        n_chk++;
        if ({bus.cmrg_coord_in_0_ready, bus.cmrg_coord_in_1_ready,
             bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid} !== 4'b0000)
            $display("FAIL flush_quiet: got %b required 0000", {bus.cmrg_coord_in_0_ready,
                     bus.cmrg_coord_in_1_ready, bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid});
        else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        q_out.delete(); q_in.delete();
        bus.cmrg_coord_in_1_valid = 1'b0;
        bus.cmrg_coord_in_0 = 17'h5; bus.cmrg_coord_in_0_valid = 1'b1;
        @(negedge clk);
        // in FETCH an inner coordinate without an outer head must not be emitted or popped
        n_chk++;
        if ({bus.cmrg_coord_in_0_ready, bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid} !== 3'b000)
            $display("FAIL flush_fetch: got %b required 000", {bus.cmrg_coord_in_0_ready,
                     bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid});
        else n_pass++;
        @(posedge clk); #1;
        bus.cmrg_coord_in_0_valid = 1'b0;
        cap0.delete(); cap1.delete(); load_basic();
        run_stream(6, 1'b0, tmo);
        n_chk++;
        if (tmo) $display("FAIL flush_timeout: got %0d/%0d tokens required 6", cap0.size(), cap1.size());
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
            if (g !== b_o0[i]) $display("FAIL flush_out0[%0d]: got %h required %h", i, g, b_o0[i]);
            else n_pass++;
            n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
            if (g !== b_o1[i]) $display("FAIL flush_out1[%0d]: got %h required %h", i, g, b_o1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_enables();
        bit tmo;
        logic [16:0] g;
        for (int which = 0; which < 2; which++) begin
            cap0.delete(); cap1.delete(); load_basic();
            run_stream(2, 1'b0, tmo);
            present_heads();
            bus.cmrg_coord_out_0_ready = 1'b1; bus.cmrg_coord_out_1_ready = 1'b1;
            if (which == 0) clk_en = 1'b0; else tile_en = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                n_chk++;
                if ({bus.cmrg_coord_in_0_ready, bus.cmrg_coord_in_1_ready,
                     bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid} !== 4'b0000)
                    $display("FAIL en_low%0d_c%0d: got %b required 0000", which, c,
                             {bus.cmrg_coord_in_0_ready, bus.cmrg_coord_in_1_ready,
                              bus.cmrg_coord_out_0_valid, bus.cmrg_coord_out_1_valid});
                else n_pass++;
                @(posedge clk); #1;
            end
            clk_en = 1'b1; tile_en = 1'b1;
            run_stream(6, 1'b0, tmo);
            n_chk++;
            if (tmo) $display("FAIL en_timeout%0d: got %0d/%0d tokens required 6", which, cap0.size(), cap1.size());
            else n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_chk++; g = (i < cap0.size()) ? cap0[i] : 'x;
                if (g !== b_o0[i]) $display("FAIL en_out0[%0d]: got %h required %h", i, g, b_o0[i]);
                else n_pass++;
                n_chk++; g = (i < cap1.size()) ? cap1[i] : 'x;
                if (g !== b_o1[i]) $display("FAIL en_out1[%0d]: got %h required %h", i, g, b_o1[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.cmrg_coord_in_0 = '0; bus.cmrg_coord_in_0_valid = 1'b0;
        bus.cmrg_coord_in_1 = '0; bus.cmrg_coord_in_1_valid = 1'b0;
        bus.cmrg_coord_out_0_ready = 1'b0; bus.cmrg_coord_out_1_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty_fiber();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_enables();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/crd_hold.md
# crd_hold

Sparse-stream coordinate-hold primitive for the sparse-tensor pipeline. It repeats, or "holds", the current outer-level coordinate once for every inner-level coordinate. The inner stream passes through unchanged, and both output streams carry identical stop/done structure. It sits between a level scanner's outer and inner coordinate streams and a downstream joiner or writer, which sees aligned (outer, inner) pairs.

## Interface
- No parameters. Token width is fixed at 17 bits.
- clk  in  1  sole clock; all state is on the rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), despite the name.
- clk_en  in  1  when 0, every register holds, all readies are 0 and all valids are 0.
- flush  in  1  synchronous; same effect as reset.
- tile_en  in  1  when 0, behaves as clk_en=0.
- cmrg_enable  in  1  ignored.
- cmrg_stop_lvl  in  16  ignored.
- cmrg_coord_in_0 / _valid / _ready  in/in/out  17/1/1  inner coordinate stream.
- cmrg_coord_in_1 / _valid / _ready  in/in/out  17/1/1  outer coordinate stream.
- cmrg_coord_out_0 / _valid / _ready  out/out/in  17/1/1  inner passthrough.
- cmrg_coord_out_1 / _valid / _ready  out/out/in  17/1/1  held outer coordinate, aligned with out_0.

## Operation
- Token format:
  - bit16=0: coordinate, value in [15:0].
  - bit16=1, bit8=0: stop token, level in [7:0].
  - bit16=1, bit8=1: done token (17'h10100).
- Handshake: a transfer occurs when valid & ready at a rising edge.
- State FETCH, behaviour by outer-head token:
  - Coordinate: pop it, latch it into held, go to HOLD.
  - Stop: pop and discard it; the inner stream carries the corresponding stop one level higher.
  - Done: wait for the inner head to be done as well. Then emit done on both outputs, pop both inputs, and stay in FETCH for the next tile.
  - Inner input is never popped in FETCH except on the done/done case.
- State HOLD, behaviour by inner-head token:
  - Coordinate c: emit out_0=c and out_1=held, pop the inner token.
  - Stop Sk: emit Sk on both outputs, pop it, go to FETCH.
  - Done (protocol error): go to FETCH without popping.
- Emission always writes both outputs in the same cycle; the two outputs never diverge in token count.
- Outer input ready = (state==FETCH) & emission-capacity-ok, or equivalent. Ready must never depend combinationally on the same port's valid.

## Timing
- Reset/flush values:
  - All outputs valid=0, data=0.
  - Both input readies 0 during reset.
  - state=FETCH, held=0, output stages empty.
- Latency:
  - Without CRD_HOLD_OUT_REG_EN: 0 cycles, emission combinational from inner head, and emission requires both out readies = 1.
  - With the macro: 1 cycle.
- Throughput: one inner token per cycle in HOLD. An outer coordinate fetch costs one cycle (FETCH→HOLD); discarded outer stops cost one cycle each.
- Backpressure: if either output cannot accept, nothing is popped and held/state are unchanged.
- A valid, once asserted, is held with stable data until ready.
- Reset or flush mid-tile discards held, state and queued outputs; the next cycle starts clean in FETCH.

## Configuration
- CRD_HOLD_OUT_REG_EN defined: each output has a 2-entry FIFO. Outputs are driven from the FIFO heads, so there is no combinational in→out path. Emission requires both FIFOs not full. Out valid = FIFO not empty, and each output drains independently.
- Not defined: outputs are combinational from the inner head and held, and out valids are asserted together.

## Test plan
- Basic tile:
  - Stimulus: outer 0,1,S0(10000),D; inner 0,2,S0,1,S1(10001),D.
  - Required: out_0 = 0,2,S0,1,S1,D and out_1 = 0,0,S0,1,S1,D.
- Empty inner fiber:
  - Stimulus: outer 3,4,S0,D; inner S0,7,S1,D.
  - Required: out_0 = S0,7,S1,D and out_1 = S0,4,S1,D.
- Random backpressure:
  - Stimulus: basic tile with out_0/out_1 ready toggling independently and input valids randomly gapped.
  - Required: identical streams, no duplication or loss, and valid/data stable while stalled.
- Back-to-back tiles:
  - Stimulus: two basic tiles in sequence.
  - Required: two done tokens, second tile output identical to the first.
- Flush mid-stream:
  - Stimulus: assert flush after out emits 0,0.
  - Required: valids drop next cycle, state FETCH, and a new basic tile produces the exact expected output.
- clk_en/tile_en low:
  - Stimulus: drive clk_en or tile_en low for 5 cycles mid-tile.
  - Required: all readies/valids 0, no tokens consumed, and output resumes unchanged afterwards.
